// File: rtl/mbinit_repairval_module_pkg.sv
// ---------------------------------------------------------------------------
// mbinit_repairval_module_pkg
// Shared definitions for the MBINIT.REPAIRVAL link-training stage:
//   - sideband message codes exchanged with the link partner
//   - bit positions inside the partner's repair-valid result
//   - FSM state encoding and the registered-output bundle
//   - stateOutputs(): per-state decode of the registered outputs
// No ports (package).
// ---------------------------------------------------------------------------
package mbinit_repairval_module_pkg;

  // Sideband message codes; zero means "nothing to send".
  localparam logic [3:0] MSG_NONE        = 4'd0;
  localparam logic [3:0] MSG_INIT_REQ    = 4'd1;
  localparam logic [3:0] MSG_INIT_RESP   = 4'd2;
  localparam logic [3:0] MSG_RESULT_REQ  = 4'd3;
  localparam logic [3:0] MSG_RESULT_RESP = 4'd4;
  localparam logic [3:0] MSG_DONE_REQ    = 4'd5;
  localparam logic [3:0] MSG_DONE_RESP   = 4'd6;

  // Result payload bit positions.
  localparam int RES_PRIMARY_BIT   = 0;
  localparam int RES_REDUNDANT_BIT = 1;

  typedef enum logic [3:0] {
    ST_IDLE             = 4'd0,
    ST_WAIT_BUSY_INIT   = 4'd1,
    ST_SEND_INIT        = 4'd2,
    ST_WAIT_RESP        = 4'd3,
    ST_SEND_PATTERN     = 4'd4,
    ST_WAIT_BUSY_RESULT = 4'd5,
    ST_SEND_RESULT      = 4'd6,
    ST_EVAL             = 4'd7,
    ST_WAIT_BUSY_DONE   = 4'd8,
    ST_SEND_DONE        = 4'd9,
    ST_COMPLETE         = 4'd10,
    ST_ERROR            = 4'd11
  } state_e;

  // Outputs that are a pure function of the state being entered.
  typedef struct packed {
    logic [3:0] txMsg;
    logic       txValid;
    logic       patternEn;
    logic       endLevel;
    logic       trainError;
  } out_t;

  // Outputs are decoded from the next state and registered, so they line up
  // with the state register rather than trailing it by a cycle.
  function automatic out_t stateOutputs(input state_e s);
    out_t o;
    o = '0;
    o.txMsg = MSG_NONE;
    case (s)
      ST_SEND_INIT: begin
        o.txValid = 1'b1;
        o.txMsg   = MSG_INIT_REQ;
      end
      ST_SEND_RESULT: begin
        o.txValid = 1'b1;
        o.txMsg   = MSG_RESULT_REQ;
      end
      ST_SEND_DONE: begin
        o.txValid = 1'b1;
        o.txMsg   = MSG_DONE_REQ;
      end
      ST_SEND_PATTERN: o.patternEn  = 1'b1;
      ST_COMPLETE:     o.endLevel   = 1'b1;
      ST_ERROR:        o.trainError = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/sb_timeout_counter.sv
// ---------------------------------------------------------------------------
// sb_timeout_counter
// Cycle counter guarding a wait for a sideband response.
//   clk_i      in  clock
//   rst_i      in  synchronous active-high reset
//   clear_i    in  restart the count at zero (wins over enable_i)
//   enable_i   in  count this cycle
//   expired_o  out count has reached TIMEOUT_CYCLES-1 (combinational)
// ---------------------------------------------------------------------------
module sb_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 800000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  // The count holds once expired so it can never wrap back to a safe value
  // if the owner is slow to leave its wait state.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !expired_o) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == LAST_COUNT);

endmodule

// File: rtl/mbinit_repairval_module.sv
// ---------------------------------------------------------------------------
// mbinit_repairval_module
// MBINIT.REPAIRVAL link-training stage. Runs the init / valid-train / result /
// done sideband handshakes, chooses primary or redundant valid lane from the
// partner's result, then either raises the stage-complete level for
// REVERSALMB or requests TRAINERROR.
//   CLK                         in   clock
//   rst                         in   synchronous active-high reset
//   i_MBINIT_REPAIRCLK_end      in   stage enable (low aborts to IDLE)
//   i_Rx_SbMessage[3:0]         in   received sideband message
//   i_msg_valid                 in   i_Rx_SbMessage valid
//   i_Busy_SideBand             in   sideband TX busy
//   i_falling_edge_busy         in   sideband TX finished a message (pulse)
//   i_VAL_Pattern_done          in   valid-pattern generator finished
//   i_REPAIRVAL_Result_SB[1:0]  in   [0]=primary pass, [1]=redundant pass
//   o_TX_SbMessage[3:0]         out  message to transmit
//   o_tx_data_valid_repairval   out  o_TX_SbMessage valid
//   o_VAL_Pattern_En            out  valid-pattern generator enable
//   o_val_lane_sel              out  0=primary, 1=redundant valid lane
//   o_MBINIT_REPAIRVAL_end      out  stage complete level
//   o_train_error_req_repairval out  TRAINERROR request level
// ---------------------------------------------------------------------------
module mbinit_repairval_module #(
  parameter int TIMEOUT_CYCLES = 800000
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       i_MBINIT_REPAIRCLK_end,
  input  logic [3:0] i_Rx_SbMessage,
  input  logic       i_msg_valid,
  input  logic       i_Busy_SideBand,
  input  logic       i_falling_edge_busy,
  input  logic       i_VAL_Pattern_done,
  input  logic [1:0] i_REPAIRVAL_Result_SB,
  output logic [3:0] o_TX_SbMessage,
  output logic       o_tx_data_valid_repairval,
  output logic       o_VAL_Pattern_En,
  output logic       o_val_lane_sel,
  output logic       o_MBINIT_REPAIRVAL_end,
  output logic       o_train_error_req_repairval
);

  import mbinit_repairval_module_pkg::*;

  state_e     state_q, state_d;
  logic [3:0] expResp_q, expResp_d;
  logic [1:0] result_q, result_d;
  logic       laneSel_q, laneSel_d;
  out_t       outs_q, outs_d;

  logic respMatch;
  logic toClear;
  logic toEnable;
  logic toExpired;

  // A response only counts while we are actually waiting for one.
  assign respMatch = (state_q == ST_WAIT_RESP) && i_msg_valid &&
                     (i_Rx_SbMessage == expResp_q);

  // The timeout restarts on every entry into WAIT_RESP, since the same wait
  // state is reused for all three handshakes.
  assign toClear  = (state_d == ST_WAIT_RESP) && (state_q != ST_WAIT_RESP);
  assign toEnable = (state_q == ST_WAIT_RESP);

  sb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (CLK),
    .rst_i    (rst),
    .clear_i  (toClear),
    .enable_i (toEnable),
    .expired_o(toExpired)
  );

  // Next-state and next-output logic. Dropping the enable overrides every
  // other event; a matching response beats a same-cycle timeout.
  always_comb begin
    state_d   = state_q;
    expResp_d = expResp_q;
    result_d  = result_q;
    laneSel_d = laneSel_q;

    if (!i_MBINIT_REPAIRCLK_end) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_WAIT_BUSY_INIT;

        ST_WAIT_BUSY_INIT: if (!i_Busy_SideBand) state_d = ST_SEND_INIT;

        ST_SEND_INIT: begin
          if (i_falling_edge_busy) begin
            state_d   = ST_WAIT_RESP;
            expResp_d = MSG_INIT_RESP;
          end
        end

        ST_WAIT_RESP: begin
          if (respMatch) begin
            case (expResp_q)
              MSG_INIT_RESP: state_d = ST_SEND_PATTERN;
              MSG_RESULT_RESP: begin
                state_d  = ST_EVAL;
                result_d = i_REPAIRVAL_Result_SB;
              end
              MSG_DONE_RESP: state_d = ST_COMPLETE;
              default:       state_d = ST_ERROR;
            endcase
          end else if (toExpired) begin
            state_d = ST_ERROR;
          end
        end

        ST_SEND_PATTERN: if (i_VAL_Pattern_done) state_d = ST_WAIT_BUSY_RESULT;

        ST_WAIT_BUSY_RESULT: if (!i_Busy_SideBand) state_d = ST_SEND_RESULT;

        ST_SEND_RESULT: begin
          if (i_falling_edge_busy) begin
            state_d   = ST_WAIT_RESP;
            expResp_d = MSG_RESULT_RESP;
          end
        end

        // Primary lane is preferred whenever it passed.
        ST_EVAL: begin
          if (result_q[RES_PRIMARY_BIT]) begin
            laneSel_d = 1'b0;
            state_d   = ST_WAIT_BUSY_DONE;
          end else if (result_q[RES_REDUNDANT_BIT]) begin
            laneSel_d = 1'b1;
            state_d   = ST_WAIT_BUSY_DONE;
          end else begin
            state_d = ST_ERROR;
          end
        end

        ST_WAIT_BUSY_DONE: if (!i_Busy_SideBand) state_d = ST_SEND_DONE;

        ST_SEND_DONE: begin
          if (i_falling_edge_busy) begin
            state_d   = ST_WAIT_RESP;
            expResp_d = MSG_DONE_RESP;
          end
        end

        ST_COMPLETE: state_d = ST_COMPLETE;
        ST_ERROR:    state_d = ST_ERROR;
        default:     state_d = ST_IDLE;
      endcase
    end

    // Returning to IDLE forgets the lane choice and the pending handshake.
    if (state_d == ST_IDLE) begin
      laneSel_d = 1'b0;
      expResp_d = MSG_NONE;
    end

    outs_d = stateOutputs(state_d);
  end

  // State and registered outputs.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      expResp_q <= MSG_NONE;
      result_q  <= '0;
      laneSel_q <= 1'b0;
      outs_q    <= '0;
    end else begin
      state_q   <= state_d;
      expResp_q <= expResp_d;
      result_q  <= result_d;
      laneSel_q <= laneSel_d;
      outs_q    <= outs_d;
    end
  end

  assign o_TX_SbMessage              = outs_q.txMsg;
  assign o_tx_data_valid_repairval   = outs_q.txValid;
  assign o_VAL_Pattern_En            = outs_q.patternEn;
  assign o_MBINIT_REPAIRVAL_end      = outs_q.endLevel;
  assign o_train_error_req_repairval = outs_q.trainError;
  assign o_val_lane_sel              = laneSel_q;

endmodule
